// File: rtl/clz_normalizer_ctrl_pkg.sv
// Shared definitions for the multi-cycle leading-zero normaliser.
// Holds the FSM state encodings and the count-width helper.
package clz_normalizer_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // A count of leading zeros over w bits ranges 0..w, so it needs one extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/clz_normalizer_ctrl_count_lead_zero.sv
// Narrow combinational leading-zero counter shared across chunks in time.
// An all-zero input returns W_IN, which callers use as the all-zero flag.
module count_lead_zero #(
    parameter int W_IN  = 8,
    parameter int W_OUT = $clog2(W_IN) + 1
) (
    input  logic [W_IN-1:0]  in_bits,
    output logic [W_OUT-1:0] count
);

    // Scan LSB to MSB so the highest set bit is the last one to write the count.
    always_comb begin
        count = W_OUT'(W_IN);
        for (int i = 0; i < W_IN; i++) begin
            if (in_bits[i]) begin
                count = W_OUT'(W_IN - 1 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/clz_normalizer_ctrl.sv
// Multi-cycle normaliser: scans the word MSB-first one chunk per cycle through a
// single narrow leading-zero counter, then barrel-shifts the word left once.
module clz_normalizer_ctrl
    import clz_normalizer_ctrl_pkg::*;
#(
    parameter int W_DATA  = 32,
    parameter int W_CHUNK = 8,
    parameter int W_CNT   = cnt_width(W_DATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_DATA-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] out_data,
    output logic [W_CNT-1:0]  out_count,
    output logic              out_zero
);

    localparam int NCH   = W_DATA / W_CHUNK;
    localparam int W_IDX = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int W_CLZ = $clog2(W_CHUNK) + 1;

    logic [1:0]                    state_r;
    logic [W_DATA-1:0]             work_r;
    logic [W_IDX-1:0]              idx_r;
    logic [W_CNT-1:0]              acc_r;
    logic [W_DATA-1:0]             out_data_r;
    logic [W_CNT-1:0]              out_count_r;
    logic                          out_zero_r;

    logic [NCH-1:0][W_CHUNK-1:0]   chunks_s;
    logic [W_CHUNK-1:0]            chunk_s;
    logic [W_CLZ-1:0]              clz_s;
    logic                          chunk_zero_s;
    logic                          last_chunk_s;
    logic [W_CNT-1:0]              acc_next_s;

    assign chunks_s = work_r;

    // Chunk 0 is the MSB chunk, which sits at the top packed index.
    always_comb begin
        chunk_s      = chunks_s[W_IDX'(NCH - 1) - idx_r];
        chunk_zero_s = (clz_s == W_CLZ'(W_CHUNK));
        last_chunk_s = (idx_r == W_IDX'(NCH - 1));
        acc_next_s   = acc_r + W_CNT'(clz_s);
    end

    count_lead_zero #(
        .W_IN  (W_CHUNK),
        .W_OUT (W_CLZ)
    ) u_clz (
        .in_bits (chunk_s),
        .count   (clz_s)
    );

    // Control FSM plus working and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            work_r      <= '0;
            idx_r       <= '0;
            acc_r       <= '0;
            out_data_r  <= '0;
            out_count_r <= '0;
            out_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_r  <= in_data;
                        idx_r   <= '0;
                        acc_r   <= '0;
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // An all-zero chunk adds W_CHUNK, which is exactly what the counter returns.
                    acc_r <= acc_next_s;
                    if (!chunk_zero_s) begin
                        state_r <= ST_SHIFT;
                    end else if (last_chunk_s) begin
                        out_data_r  <= '0;
                        out_count_r <= W_CNT'(W_DATA);
                        out_zero_r  <= 1'b1;
                        state_r     <= ST_HOLD;
                    end else begin
                        idx_r <= idx_r + W_IDX'(1);
                    end
                end
                ST_SHIFT: begin
                    out_data_r  <= work_r << acc_r;
                    out_count_r <= acc_r;
                    out_zero_r  <= 1'b0;
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE) & ~rst;
    assign out_valid = (state_r == ST_HOLD);
    assign out_data  = out_data_r;
    assign out_count = out_count_r;
    assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_clz_normalizer_ctrl.sv
// Self-checking bench for clz_normalizer_ctrl (W_DATA=32, W_CHUNK=8) using a
// scoreboard queue filled at accept time and drained when out_valid rises.
module tb_clz_normalizer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_count;
    logic        out_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  count;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    clz_normalizer_ctrl #(
        .W_DATA  (32),
        .W_CHUNK (8),
        .W_CNT   (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] d);
        exp_t m;
        int   c;
        c = 0;
        while (c < 32) begin
            if (d[31 - c]) break;
            c++;
        end
        m.count = 6'(c);
        m.zero  = (c == 32);
        m.data  = (c == 32) ? 32'h0 : (d << c);
        m.lat   = (c == 32) ? 4 : (c / 8 + 2);
        return m;
    endfunction

    // Waits for in_ready, presents one word for one edge and records its expectation.
    task automatic accept_word(input logic [31:0] d);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        sb_q.push_back(model(d));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_count !== 6'd0 || out_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h cnt=%0d zero=%b required 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_count, out_zero);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vec[$];
        exp_t        e;
        int          lat;
        vec = '{32'h8000_0000, 32'h0001_2345, 32'h0000_0001, 32'h0000_0000,
                32'h0080_0000, 32'hFFFF_FFFF, 32'h0000_4000};
        for (int i = 0; i < 8; i++) begin
            vec.push_back($urandom >> $urandom_range(0, 31));
        end
        foreach (vec[i]) begin
            accept_word(vec[i]);
            lat = 0;
            while (out_valid !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            e = sb_q.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("FAIL latency[%h]: got %0d required %0d", vec[i], lat, e.lat);
            end
            checks++;
            if (out_data !== e.data) begin
                failures++;
                $display("FAIL out_data[%h]: got %h required %h", vec[i], out_data, e.data);
            end
            checks++;
            if (out_count !== e.count) begin
                failures++;
                $display("FAIL out_count[%h]: got %0d required %0d", vec[i], out_count, e.count);
            end
            checks++;
            if (out_zero !== e.zero) begin
                failures++;
                $display("FAIL out_zero[%h]: got %b required %b", vec[i], out_zero, e.zero);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL release[%h]: vld=%b rdy=%b required 0 1", vec[i], out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        int   bad;
        accept_word(32'h0001_2345);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL hold_latency: got %0d required 3", lat);
        end
        in_valid = 1'b1;
        in_data  = 32'hFF00_0000;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data ||
                out_count !== e.count || out_zero !== e.zero) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable: %0d unstable cycles, data=%h cnt=%0d required %h %0d",
                     bad, out_data, out_count, e.data, e.count);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_gap: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        sb_q.push_back(model(32'hFF00_0000));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL next_accept: in_ready=%b required 0", in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        checks++;
        if (lat !== e.lat || out_data !== e.data || out_count !== e.count) begin
            failures++;
            $display("FAIL next_word: lat=%0d data=%h cnt=%0d required %0d %h %0d",
                     lat, out_data, out_count, e.lat, e.data, e.count);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_rst_mid_scan();
        exp_t e;
        int   seen;
        int   lat;
        accept_word(32'h0000_0001);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready_low: in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_count !== 6'd0 || out_zero !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_scan: rdy=%b vld=%b data=%h cnt=%0d zero=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_count, out_zero);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_no_valid: out_valid seen %0d times required 0", seen);
        end
        accept_word(32'h0000_0001);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        checks++;
        if (lat !== 5 || out_count !== e.count || out_data !== e.data) begin
            failures++;
            $display("FAIL post_rst_word: lat=%0d cnt=%0d data=%h required 5 %0d %h",
                     lat, out_count, out_data, e.count, e.data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_rst_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
